// File: rtl/hstx_lane_ctrl.sv
// Lane sequencer in front of hstx_fsm: LP-11 -> LP-01 -> LP-00 entry, HS byte
// pass-through with TxReadyHS handshake, HS trail/exit and return to LP-11 stop.
module hstx_lane_ctrl #(
  parameter logic [7:0] TLPX          = 8'd4,
  parameter logic [7:0] THS_PREPARE   = 8'd6,
  parameter logic [7:0] TRAIL_WAIT    = 8'd17,
  parameter logic [7:0] THS_EXIT      = 8'd10,
  parameter logic [7:0] START_TIMEOUT = 8'd64
) (
  input  logic       TxDDRClkHS,
  input  logic       TxRst_n,
  input  logic       TxRequestHS,
  input  logic [7:0] TxDataHS,
  output logic       TxReadyHS,
  input  logic [2:0] HsTxState,
  output logic       SOT,
  output logic       TxValid,
  output logic [7:0] TxByte_Data,
  output logic       LP_Dp,
  output logic       LP_Dn,
  output logic       hs_oe,
  output logic       Stop_state,
  output logic       err_timeout,
  output logic [2:0] CtrlState
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LP_RQST   = 3'd1,
    LP_PREP   = 3'd2,
    HS_START  = 3'd3,
    HS_ACTIVE = 3'd4,
    HS_EXIT   = 3'd5,
    LP_EXIT   = 3'd6
  } state_t;

  localparam logic [2:0] HS_DATA = 3'b011;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       dp_q, dp_d, dn_q, dn_d;
  logic       oe_q, oe_d, sot_q, sot_d, stop_q, stop_d;
  logic       active;

  // Handshake: a byte moves in any cycle where TxRequestHS && TxReadyHS;
  // TxReadyHS is high for the whole of HS_ACTIVE, so there is no backpressure.
  always_ff @(posedge TxDDRClkHS or negedge TxRst_n) begin
    if (!TxRst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
      dp_q    <= 1'b1;
      dn_q    <= 1'b1;
      oe_q    <= 1'b0;
      sot_q   <= 1'b0;
      stop_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      dp_q    <= dp_d;
      dn_q    <= dn_d;
      oe_q    <= oe_d;
      sot_q   <= sot_d;
      stop_q  <= stop_d;
    end
  end

  // Next state: every timed phase loads (param - 1) on entry and leaves at 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (TxRequestHS) begin
          state_d = LP_RQST;
          cnt_d   = TLPX - 8'd1;
        end
      end
      LP_RQST: begin
        if (!TxRequestHS) begin
          state_d = LP_EXIT;
          cnt_d   = THS_EXIT - 8'd1;
        end else if (cnt_q == 8'd0) begin
          state_d = LP_PREP;
          cnt_d   = THS_PREPARE - 8'd1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      LP_PREP: begin
        if (!TxRequestHS) begin
          state_d = LP_EXIT;
          cnt_d   = THS_EXIT - 8'd1;
        end else if (cnt_q == 8'd0) begin
          state_d = HS_START;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HS_START: begin
        // Counts up here; the timeout fires on the START_TIMEOUT-th cycle.
        if (HsTxState == HS_DATA) begin
          state_d = HS_ACTIVE;
          cnt_d   = 8'd0;
        end else if (!TxRequestHS) begin
          state_d = HS_EXIT;
          cnt_d   = TRAIL_WAIT - 8'd1;
        end else if (cnt_q == START_TIMEOUT - 8'd1) begin
          state_d = HS_EXIT;
          cnt_d   = TRAIL_WAIT - 8'd1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HS_ACTIVE: begin
        if (!TxRequestHS) begin
          state_d = HS_EXIT;
          cnt_d   = TRAIL_WAIT - 8'd1;
        end
      end
      HS_EXIT: begin
        if (cnt_q == 8'd0) begin
          state_d = LP_EXIT;
          cnt_d   = THS_EXIT - 8'd1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      LP_EXIT: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Line levels are decoded from the next state so they register with it.
  always_comb begin
    dp_d   = 1'b1;
    dn_d   = 1'b1;
    oe_d   = 1'b0;
    sot_d  = 1'b0;
    stop_d = 1'b0;
    case (state_d)
      IDLE:    stop_d = 1'b1;
      LP_RQST: dp_d = 1'b0;
      LP_PREP: begin
        dp_d = 1'b0;
        dn_d = 1'b0;
      end
      HS_START, HS_ACTIVE: begin
        dp_d  = 1'b0;
        dn_d  = 1'b0;
        oe_d  = 1'b1;
        sot_d = 1'b1;
      end
      HS_EXIT: begin
        dp_d = 1'b0;
        dn_d = 1'b0;
        oe_d = 1'b1;
      end
      LP_EXIT: stop_d = 1'b0;
      default: stop_d = 1'b1;
    endcase
  end

  assign active      = (state_q == HS_ACTIVE);
  assign TxReadyHS   = active;
  assign TxValid     = active & TxRequestHS;
  assign TxByte_Data = active ? TxDataHS : 8'h00;

  assign SOT         = sot_q;
  assign LP_Dp       = dp_q;
  assign LP_Dn       = dn_q;
  assign hs_oe       = oe_q;
  assign Stop_state  = stop_q;
  assign err_timeout = err_q;
  assign CtrlState   = state_q;

endmodule

// File: doc/hstx_lane_ctrl.md
# hstx_lane_ctrl

Lane-level sequencer that sits between the protocol layer and `hstx_fsm`. It owns the LP-to-HS entry sequence (LP-11 → LP-01 → LP-00), drives `SOT`/`TxValid`/`TxByte_Data` into the HS FSM, and handshakes bytes with the requester through `TxReadyHS`. It also owns HS exit and the return to LP-11 stop state, and enforces the D-PHY timing intervals with a single down-counter.

## Interface
- `TLPX`, 8'd4: cycles in LP-01 (HS request).
- `THS_PREPARE`, 8'd6: cycles in LP-00 before `SOT` asserts.
- `TRAIL_WAIT`, 8'd17: cycles after `SOT` drops, covering HS trail plus margin; must be ≥ HS FSM trail time + 2.
- `THS_EXIT`, 8'd10: cycles of LP-11 before the block is idle again.
- `START_TIMEOUT`, 8'd64: maximum cycles waiting for the HS FSM to reach DATA.
- Timing parameters are each ≥ 1.

Ports:
- `TxDDRClkHS` in 1: the only clock.
- `TxRst_n` in 1: asynchronous, active-low reset.
- `TxRequestHS` in 1: requester wants HS transmission; while in HS it also means a byte is valid.
- `TxDataHS` in 8: byte from the requester.
- `TxReadyHS` out 1: byte accepted this cycle when `TxRequestHS && TxReadyHS`.
- `HsTxState` in 3: `TxState` output of `hstx_fsm`. 3'b011 = DATA.
- `SOT` out 1: to `hstx_fsm`.
- `TxValid` out 1: to `hstx_fsm`.
- `TxByte_Data` out 8: to `hstx_fsm`.
- `LP_Dp`, `LP_Dn` out 1 each: LP line levels.
- `hs_oe` out 1: enables the HS driver.
- `Stop_state` out 1: lane is in LP-11 idle.
- `err_timeout` out 1: sticky; set when `START_TIMEOUT` expires.
- `CtrlState` out 3: state, for debug.

## Operation
States and `CtrlState` encodings:
- IDLE = 0
- LP_RQST = 1
- LP_PREP = 2
- HS_START = 3
- HS_ACTIVE = 4
- HS_EXIT = 5
- LP_EXIT = 6
- Encodings 7 is unused; it recovers to IDLE.

State outputs:
- State-decoded outputs (`LP_Dp`, `LP_Dn`, `hs_oe`, `SOT`, `Stop_state`) are registered. They change on the same edge as the state register.
- IDLE: LP=11, `Stop_state`=1, `hs_oe`=0, `SOT`=0.
- LP_RQST: LP=01.
- LP_PREP: LP=00.
- HS_START and HS_ACTIVE: LP=00, `hs_oe`=1, `SOT`=1.
- HS_EXIT: LP=00, `hs_oe`=1, `SOT`=0.
- LP_EXIT: LP=11, `hs_oe`=0.

Transitions:
- IDLE → LP_RQST when `TxRequestHS`=1.
- LP_RQST → LP_PREP after `TLPX` cycles.
- LP_PREP → HS_START after `THS_PREPARE` cycles.
- LP_RQST or LP_PREP with `TxRequestHS`=0 → LP_EXIT. This abort takes priority over counter expiry.
- HS_START → HS_ACTIVE when `HsTxState`==3'b011.
- HS_START with `TxRequestHS`=0 → HS_EXIT.
- HS_START after `START_TIMEOUT` cycles → HS_EXIT and set `err_timeout`.
- Priority in HS_START: DATA reached > request drop > timeout.
- HS_ACTIVE → HS_EXIT when `TxRequestHS`=0.
- HS_EXIT → LP_EXIT after `TRAIL_WAIT` cycles. `TxRequestHS` is ignored in this state.
- LP_EXIT → IDLE after `THS_EXIT` cycles. `TxRequestHS` is ignored in this state.

Counter:
- 8-bit, loaded with (param − 1) on state entry and decremented each cycle.
- The exit condition is count==0 while in the state, so a phase lasts exactly param cycles.
- In HS_START the counter counts up to `START_TIMEOUT` instead.

Datapath:
- Combinational pass-through, active in HS_ACTIVE only: `TxValid`=`TxRequestHS`, `TxByte_Data`=`TxDataHS`, `TxReadyHS`=1.
- Outside HS_ACTIVE: `TxValid`=0, `TxByte_Data`=8'h00, `TxReadyHS`=0.

`err_timeout`:
- Cleared only by reset.
- Does not block further requests.

## Timing
Reset values:
- `CtrlState`=IDLE, `LP_Dp`=`LP_Dn`=1, `Stop_state`=1.
- `hs_oe`=0, `SOT`=0, `TxValid`=0, `TxByte_Data`=0, `TxReadyHS`=0, `err_timeout`=0.
- Counter = 0.

Reset mid-operation:
- All outputs return to their reset values immediately, asynchronously.
- The first state after release is IDLE.

Latency:
- `TxRequestHS` sampled high in IDLE at edge N → LP=01 from edge N+1.
- `SOT`=1 from edge N+1+`TLPX`+`THS_PREPARE`.

Byte acceptance:
- The first `TxReadyHS` is the cycle after `HsTxState`=3'b011 is observed.
- One byte per cycle, with no backpressure once ready.
- Dropping `TxRequestHS` ends the burst. `SOT` falls on the next edge; the cycle in which `TxRequestHS` is low transfers no byte.

Restart:
- `TxRequestHS` held high through LP_EXIT → IDLE for exactly 1 cycle, then LP_RQST.

## Test plan
- **Reset:** assert `TxRst_n`=0 mid-HS_ACTIVE → all outputs at reset values within the same cycle; `CtrlState`=0 after release.
- **Nominal burst (defaults):** hold `TxRequestHS`; model HS FSM reporting DATA 16 cycles after `SOT` rises; send 5 bytes 0xA1..0xA5.
  - LP=01 for 4 cycles, then LP=00 for 6 cycles before `SOT` rises.
  - Exactly 5 accepted bytes appear in order on `TxByte_Data` with `TxValid`=1.
  - `hs_oe` stays high for 17 cycles after `SOT` falls.
  - LP=11 for 10 cycles, then `Stop_state`=1.
- **Abort in LP_PREP:** drop `TxRequestHS` in LP_PREP cycle 3 → LP_EXIT next edge; `SOT` never asserts; `hs_oe` stays 0.
- **Timeout:** `HsTxState` never reaches 3'b011 → after 64 cycles in HS_START, `err_timeout`=1, `SOT`=0, then HS_EXIT and LP_EXIT; `err_timeout` stays 1 in IDLE.
- **Back-to-back:** keep `TxRequestHS`=1 through LP_EXIT → exactly one IDLE cycle, then a new LP-01 sequence.
- **Simultaneous events:** drop `TxRequestHS` in the same cycle that `HsTxState`=3'b011 in HS_START → HS_ACTIVE is entered, then HS_EXIT on the next edge with zero bytes accepted.
